// File: rtl/ttc_cmd_decoder.sv
// ttc_cmd_decoder
//   Turns the 4-bit per-BX TTC command stream into single-cycle strobes.
//   It also applies per-command masking, drops L1As for a holdoff window
//   after Resync/HardReset, checks the BC0 period, and keeps saturating
//   command counters.
//
// Ports
//   clock, reset            40 MHz clock, synchronous active-high reset
//   ttc_cmd, ttc_cmd_valid  encoded command and its qualifier
//   cmd_mask                bit n enables command code n (bit 0 unused)
//   cnt_reset               clears all counters and bc0_period_err
//   ttc_l1a .. ttc_calpulse registered command strobes, 1 clock after input
//   l1a_cnt, bc0_cnt,
//   resync_cnt, invalid_cnt saturating MXCNT-bit event counters
//   l1a_holdoff             high while L1As are dropped after Resync
//   bc0_period_err          sticky BC0 spacing error
module ttc_cmd_decoder #(
    parameter int MXCNT          = 32,
    parameter int LHC_CYCLE      = 3564,
    parameter int RESYNC_HOLDOFF = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ttc_cmd,
    input  logic             ttc_cmd_valid,
    input  logic [7:0]       cmd_mask,
    input  logic             cnt_reset,
    output logic             ttc_l1a,
    output logic             ttc_bx0,
    output logic             ttc_ec0,
    output logic             ttc_resync,
    output logic             ttc_oc0,
    output logic             ttc_hard_reset,
    output logic             ttc_calpulse,
    output logic [MXCNT-1:0] l1a_cnt,
    output logic [MXCNT-1:0] bc0_cnt,
    output logic [MXCNT-1:0] resync_cnt,
    output logic [MXCNT-1:0] invalid_cnt,
    output logic             l1a_holdoff,
    output logic             bc0_period_err
);

    localparam int HW = $clog2(RESYNC_HOLDOFF + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } hold_state_t;

    hold_state_t   state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;

    logic [7:0]  code_hit;
    logic [7:0]  acc;
    logic        invalid_hit;
    logic        l1a_acc;
    logic        hold_trig;
    logic [11:0] gap;
    logic        bc0_armed;
    logic        unused_bits;

    // One-hot decode of valid codes 0..7; code 0 (idle) and mask bit 0 are never used.
    always_comb begin
        code_hit = '0;
        if (ttc_cmd_valid && !ttc_cmd[3]) begin
            code_hit[ttc_cmd[2:0]] = 1'b1;
        end
    end

    assign acc         = code_hit & cmd_mask;
    assign invalid_hit = ttc_cmd_valid & ttc_cmd[3];
    assign l1a_acc     = acc[1] && (state == IDLE);
    assign hold_trig   = acc[4] | acc[6];
    assign unused_bits = ^{acc[0]};

    function automatic logic [MXCNT-1:0] sat_inc(input logic [MXCNT-1:0] v);
        return (&v) ? v : v + MXCNT'(1);
    endfunction

    // Holdoff FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Holdoff FSM: next state. Leaving on count 1 keeps HOLD for exactly
    // RESYNC_HOLDOFF clocks after the triggering command.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (hold_trig) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = HW'(RESYNC_HOLDOFF);
                end
            end
            HOLD: begin
                if (hold_trig) begin
                    hold_cnt_nxt = HW'(RESYNC_HOLDOFF);
                end else if (hold_cnt == HW'(1)) begin
                    state_nxt    = IDLE;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt - HW'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // Holdoff FSM: outputs
    always_comb begin
        l1a_holdoff = (state == HOLD);
    end

    // Command strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            ttc_l1a        <= 1'b0;
            ttc_bx0        <= 1'b0;
            ttc_ec0        <= 1'b0;
            ttc_resync     <= 1'b0;
            ttc_oc0        <= 1'b0;
            ttc_hard_reset <= 1'b0;
            ttc_calpulse   <= 1'b0;
        end else begin
            ttc_l1a        <= l1a_acc;
            ttc_bx0        <= acc[2];
            ttc_ec0        <= acc[3];
            ttc_resync     <= acc[4];
            ttc_oc0        <= acc[5];
            ttc_hard_reset <= acc[6];
            ttc_calpulse   <= acc[7];
        end
    end

    // Event counters; cnt_reset takes priority over a coincident event
    always_ff @(posedge clock) begin
        if (reset || cnt_reset) begin
            l1a_cnt     <= '0;
            bc0_cnt     <= '0;
            resync_cnt  <= '0;
            invalid_cnt <= '0;
        end else begin
            if (l1a_acc)     l1a_cnt     <= sat_inc(l1a_cnt);
            if (acc[2])      bc0_cnt     <= sat_inc(bc0_cnt);
            if (acc[4])      resync_cnt  <= sat_inc(resync_cnt);
            if (invalid_hit) invalid_cnt <= sat_inc(invalid_cnt);
        end
    end

    // BC0 period checker. gap holds the clocks since the last accepted BC0,
    // so it equals LHC_CYCLE when the next BC0 is on time.
    always_ff @(posedge clock) begin
        if (reset) begin
            gap            <= '0;
            bc0_armed      <= 1'b0;
            bc0_period_err <= 1'b0;
        end else begin
            if (acc[2]) begin
                gap <= 12'd1;
            end else if (gap != 12'hFFF) begin
                gap <= gap + 12'd1;
            end

            if (cnt_reset || acc[4]) begin
                bc0_armed <= 1'b0;
            end else if (acc[2]) begin
                bc0_armed <= 1'b1;
            end

            if (cnt_reset) begin
                bc0_period_err <= 1'b0;
            end else if (acc[2] && bc0_armed && (gap != 12'(LHC_CYCLE))) begin
                bc0_period_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ttc_cmd_decoder.sv
module tb_ttc_cmd_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ttc_cmd;
    logic       ttc_cmd_valid;
    logic [7:0] cmd_mask;
    logic       cnt_reset;

    logic        ttc_l1a, ttc_bx0, ttc_ec0, ttc_resync, ttc_oc0, ttc_hard_reset, ttc_calpulse;
    logic [31:0] l1a_cnt, bc0_cnt, resync_cnt, invalid_cnt;
    logic        l1a_holdoff, bc0_period_err;

    logic        s_l1a, s_bx0, s_ec0, s_resync, s_oc0, s_hard_reset, s_calpulse;
    logic [3:0]  s_l1a_cnt, s_bc0_cnt, s_resync_cnt, s_invalid_cnt;
    logic        s_holdoff, s_err;

    logic [6:0] strobes;
    assign strobes = {ttc_calpulse, ttc_hard_reset, ttc_oc0, ttc_resync, ttc_ec0, ttc_bx0, ttc_l1a};

    int vectors = 0;
    int miscompares = 0;

    ttc_cmd_decoder dut (
        .clock(clock), .reset(reset), .ttc_cmd(ttc_cmd), .ttc_cmd_valid(ttc_cmd_valid),
        .cmd_mask(cmd_mask), .cnt_reset(cnt_reset),
        .ttc_l1a(ttc_l1a), .ttc_bx0(ttc_bx0), .ttc_ec0(ttc_ec0), .ttc_resync(ttc_resync),
        .ttc_oc0(ttc_oc0), .ttc_hard_reset(ttc_hard_reset), .ttc_calpulse(ttc_calpulse),
        .l1a_cnt(l1a_cnt), .bc0_cnt(bc0_cnt), .resync_cnt(resync_cnt), .invalid_cnt(invalid_cnt),
        .l1a_holdoff(l1a_holdoff), .bc0_period_err(bc0_period_err)
    );

    ttc_cmd_decoder #(.MXCNT(4)) dut_sat (
        .clock(clock), .reset(reset), .ttc_cmd(ttc_cmd), .ttc_cmd_valid(ttc_cmd_valid),
        .cmd_mask(cmd_mask), .cnt_reset(cnt_reset),
        .ttc_l1a(s_l1a), .ttc_bx0(s_bx0), .ttc_ec0(s_ec0), .ttc_resync(s_resync),
        .ttc_oc0(s_oc0), .ttc_hard_reset(s_hard_reset), .ttc_calpulse(s_calpulse),
        .l1a_cnt(s_l1a_cnt), .bc0_cnt(s_bc0_cnt), .resync_cnt(s_resync_cnt), .invalid_cnt(s_invalid_cnt),
        .l1a_holdoff(s_holdoff), .bc0_period_err(s_err)
    );

    always #5 clock = ~clock;

    // Inputs set after tick() are sampled at the next rising edge; outputs
    // read after tick() reflect the edge just taken.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c);
        ttc_cmd_valid = v;
        ttc_cmd       = c;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'd0);
        repeat (n) tick();
    endtask

    task automatic clear_counters();
        drive(1'b0, 4'd0);
        cnt_reset = 1'b1;
        tick();
        cnt_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cnt_reset = 1'b0;
        cmd_mask = 8'hFE;
        drive(1'b1, 4'd1);
        repeat (3) tick();
        reset = 1'b0;
        drive(1'b0, 4'd0);
        vectors++; if (strobes !== 7'd0) begin miscompares++; $display("FAIL reset_strobes: got %0h expected 0", strobes); end
        vectors++; if (l1a_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_l1a_cnt: got %0d expected 0", l1a_cnt); end
        vectors++; if (bc0_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_bc0_cnt: got %0d expected 0", bc0_cnt); end
        vectors++; if (resync_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_resync_cnt: got %0d expected 0", resync_cnt); end
        vectors++; if (invalid_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_invalid_cnt: got %0d expected 0", invalid_cnt); end
        vectors++; if (l1a_holdoff !== 1'b0) begin miscompares++; $display("FAIL reset_holdoff: got %0b expected 0", l1a_holdoff); end
        vectors++; if (bc0_period_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b expected 0", bc0_period_err); end
        vectors++; if (s_l1a_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_sat_cnt: got %0d expected 0", s_l1a_cnt); end
    endtask

    task automatic test_strobes();
        logic [6:0] exp_s;
        cmd_mask = 8'hFE;
        drive(1'b1, 4'd1);
        vectors++; if (strobes !== 7'd0) begin miscompares++; $display("FAIL strobe_latency: got %0h expected 0", strobes); end
        for (int n = 1; n <= 7; n++) begin
            drive(1'b1, 4'(n));
            tick();
            exp_s = 7'd1 << (n - 1);
            vectors++; if (strobes !== exp_s) begin miscompares++; $display("FAIL strobe_code%0d: got %0h expected %0h", n, strobes, exp_s); end
            if (n == 4) begin
                vectors++; if (l1a_holdoff !== 1'b1) begin miscompares++; $display("FAIL holdoff_with_resync: got %0b expected 1", l1a_holdoff); end
            end
        end
        drive(1'b0, 4'd0);
        tick();
        vectors++; if (strobes !== 7'd0) begin miscompares++; $display("FAIL strobe_width: got %0h expected 0", strobes); end
        vectors++; if (l1a_cnt !== 32'd1) begin miscompares++; $display("FAIL t1_l1a_cnt: got %0d expected 1", l1a_cnt); end
        vectors++; if (bc0_cnt !== 32'd1) begin miscompares++; $display("FAIL t1_bc0_cnt: got %0d expected 1", bc0_cnt); end
        vectors++; if (resync_cnt !== 32'd1) begin miscompares++; $display("FAIL t1_resync_cnt: got %0d expected 1", resync_cnt); end
        vectors++; if (invalid_cnt !== 32'd0) begin miscompares++; $display("FAIL t1_invalid_cnt: got %0d expected 0", invalid_cnt); end
        idle(20);
    endtask

    task automatic test_mask();
        clear_counters();
        cmd_mask = 8'hFC;
        drive(1'b1, 4'd1);
        tick();
        vectors++; if (ttc_l1a !== 1'b0) begin miscompares++; $display("FAIL masked_l1a: got %0b expected 0", ttc_l1a); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd9);
            tick();
            vectors++; if (strobes !== 7'd0) begin miscompares++; $display("FAIL invalid_strobe: got %0h expected 0", strobes); end
        end
        drive(1'b0, 4'hA);
        tick();
        vectors++; if (l1a_cnt !== 32'd0) begin miscompares++; $display("FAIL masked_l1a_cnt: got %0d expected 0", l1a_cnt); end
        vectors++; if (invalid_cnt !== 32'd3) begin miscompares++; $display("FAIL invalid_cnt: got %0d expected 3", invalid_cnt); end
        cmd_mask = 8'hEF;
        drive(1'b1, 4'd4);
        tick();
        vectors++; if ({ttc_resync, l1a_holdoff} !== 2'b00) begin miscompares++; $display("FAIL masked_resync: got %0b expected 00", {ttc_resync, l1a_holdoff}); end
        cmd_mask = 8'hFE;
        drive(1'b0, 4'd1);
        tick();
        vectors++; if (ttc_l1a !== 1'b0) begin miscompares++; $display("FAIL not_valid_l1a: got %0b expected 0", ttc_l1a); end
        vectors++; if (resync_cnt !== 32'd0) begin miscompares++; $display("FAIL masked_resync_cnt: got %0d expected 0", resync_cnt); end
        idle(2);
    endtask

    task automatic test_holdoff();
        int  hold_cycles;
        logic send;
        clear_counters();
        cmd_mask = 8'hFE;
        drive(1'b1, 4'd4);
        tick();
        vectors++; if ({ttc_resync, l1a_holdoff} !== 2'b11) begin miscompares++; $display("FAIL resync_holdoff_edge: got %0b expected 11", {ttc_resync, l1a_holdoff}); end
        // k counts cycles from the ttc_resync strobe cycle (k=1)
        hold_cycles = 0;
        for (int k = 1; k <= 18; k++) begin
            if (l1a_holdoff) hold_cycles++;
            send = (k == 2) || (k == 16) || (k == 17) || (k == 18);
            drive(send, send ? 4'd1 : 4'd0);
            tick();
            vectors++; if (ttc_l1a !== (send && k >= 17)) begin miscompares++; $display("FAIL holdoff_l1a_k%0d: got %0b expected %0b", k, ttc_l1a, send && k >= 17); end
        end
        drive(1'b0, 4'd0);
        tick();
        vectors++; if (hold_cycles !== 16) begin miscompares++; $display("FAIL holdoff_len: got %0d expected 16", hold_cycles); end
        vectors++; if (l1a_cnt !== 32'd2) begin miscompares++; $display("FAIL holdoff_l1a_cnt: got %0d expected 2", l1a_cnt); end
    endtask

    task automatic test_resync_reload();
        int hold_cycles;
        clear_counters();
        drive(1'b1, 4'd4);
        tick();
        hold_cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            if (l1a_holdoff) hold_cycles++;
            drive(k == 5, (k == 5) ? 4'd4 : 4'd0);
            tick();
        end
        vectors++; if (hold_cycles !== 21) begin miscompares++; $display("FAIL reload_len: got %0d expected 21", hold_cycles); end
        vectors++; if (resync_cnt !== 32'd2) begin miscompares++; $display("FAIL reload_resync_cnt: got %0d expected 2", resync_cnt); end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 4'd4);
        tick();
        idle(3);
        vectors++; if (l1a_holdoff !== 1'b1) begin miscompares++; $display("FAIL abort_pre: got %0b expected 1", l1a_holdoff); end
        reset = 1'b1;
        cnt_reset = 1'b1;
        drive(1'b1, 4'd1);
        tick();
        vectors++; if ({l1a_holdoff, strobes} !== 8'd0) begin miscompares++; $display("FAIL abort_reset: got %0h expected 0", {l1a_holdoff, strobes}); end
        vectors++; if (resync_cnt !== 32'd0) begin miscompares++; $display("FAIL abort_resync_cnt: got %0d expected 0", resync_cnt); end
        reset = 1'b0;
        cnt_reset = 1'b0;
        idle(1);
        vectors++; if (l1a_holdoff !== 1'b0) begin miscompares++; $display("FAIL abort_post: got %0b expected 0", l1a_holdoff); end
    endtask

    task automatic test_bc0_period();
        clear_counters();
        cmd_mask = 8'hFE;
        drive(1'b1, 4'd2);
        tick();
        vectors++; if ({ttc_bx0, bc0_period_err} !== 2'b10) begin miscompares++; $display("FAIL bc0_first: got %0b expected 10", {ttc_bx0, bc0_period_err}); end
        for (int i = 1; i <= 3; i++) begin
            idle(3563);
            drive(1'b1, 4'd2);
            tick();
            vectors++; if ({ttc_bx0, bc0_period_err} !== 2'b10) begin miscompares++; $display("FAIL bc0_ontime%0d: got %0b expected 10", i, {ttc_bx0, bc0_period_err}); end
        end
        vectors++; if (bc0_cnt !== 32'd4) begin miscompares++; $display("FAIL bc0_cnt: got %0d expected 4", bc0_cnt); end
        idle(3562);
        drive(1'b1, 4'd2);
        tick();
        vectors++; if ({ttc_bx0, bc0_period_err} !== 2'b11) begin miscompares++; $display("FAIL bc0_early: got %0b expected 11", {ttc_bx0, bc0_period_err}); end
        idle(10);
        drive(1'b1, 4'd4);
        tick();
        idle(2);
        vectors++; if (bc0_period_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %0b expected 1", bc0_period_err); end
        clear_counters();
        vectors++; if (bc0_period_err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %0b expected 0", bc0_period_err); end
        vectors++; if (bc0_cnt !== 32'd0) begin miscompares++; $display("FAIL bc0_cnt_clear: got %0d expected 0", bc0_cnt); end
    endtask

    task automatic test_bc0_disarm();
        clear_counters();
        drive(1'b1, 4'd2);
        tick();
        idle(3563);
        drive(1'b1, 4'd2);
        tick();
        vectors++; if (bc0_period_err !== 1'b0) begin miscompares++; $display("FAIL disarm_ontime: got %0b expected 0", bc0_period_err); end
        idle(100);
        drive(1'b1, 4'd4);
        tick();
        idle(200);
        drive(1'b1, 4'd2);
        tick();
        vectors++; if ({ttc_bx0, bc0_period_err} !== 2'b10) begin miscompares++; $display("FAIL disarm_arbitrary: got %0b expected 10", {ttc_bx0, bc0_period_err}); end
        idle(3563);
        drive(1'b1, 4'd2);
        tick();
        vectors++; if (bc0_period_err !== 1'b0) begin miscompares++; $display("FAIL rearm_ontime: got %0b expected 0", bc0_period_err); end
        idle(2999);
        drive(1'b1, 4'd2);
        tick();
        vectors++; if (bc0_period_err !== 1'b1) begin miscompares++; $display("FAIL rearm_short: got %0b expected 1", bc0_period_err); end
        clear_counters();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_sat;
        idle(20);
        clear_counters();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'd1);
            tick();
            exp_sat = (i + 1 > 15) ? 4'hF : 4'(i + 1);
            vectors++; if (ttc_l1a !== 1'b1) begin miscompares++; $display("FAIL b2b_l1a_%0d: got %0b expected 1", i, ttc_l1a); end
            vectors++; if (s_l1a_cnt !== exp_sat) begin miscompares++; $display("FAIL sat_cnt_%0d: got %0h expected %0h", i, s_l1a_cnt, exp_sat); end
        end
        drive(1'b0, 4'd0);
        tick();
        vectors++; if (l1a_cnt !== 32'd20) begin miscompares++; $display("FAIL b2b_l1a_cnt: got %0d expected 20", l1a_cnt); end
        drive(1'b1, 4'd1);
        cnt_reset = 1'b1;
        tick();
        cnt_reset = 1'b0;
        drive(1'b0, 4'd0);
        vectors++; if (ttc_l1a !== 1'b1) begin miscompares++; $display("FAIL cntrst_strobe: got %0b expected 1", ttc_l1a); end
        vectors++; if (s_l1a_cnt !== 4'd0) begin miscompares++; $display("FAIL cntrst_sat_cnt: got %0h expected 0", s_l1a_cnt); end
        vectors++; if (l1a_cnt !== 32'd0) begin miscompares++; $display("FAIL cntrst_l1a_cnt: got %0d expected 0", l1a_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        cnt_reset = 1'b0;
        cmd_mask = 8'hFE;
        ttc_cmd = 4'd0;
        ttc_cmd_valid = 1'b0;
        test_reset();
        test_strobes();
        test_mask();
        test_holdoff();
        test_resync_reload();
        test_reset_abort();
        test_bc0_period();
        test_bc0_disarm();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
